// File: rtl/sign_extend_pkg.sv
// Shared constants and types for the sign_extend block.
//   tipo_e  : field-width select code carried on the 2-bit 'tipo' input
//   W17..W28: immediate field widths selectable by tipo
//   DATA_W  : datapath width of the extended result
//   IN_W    : width of the raw right-justified field from the decoder
package sign_extend_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IN_W   = 28;

  localparam int unsigned W17 = 17;
  localparam int unsigned W20 = 20;
  localparam int unsigned W24 = 24;
  localparam int unsigned W28 = 28;

  typedef enum logic [1:0] {
    TIPO_17 = 2'b00,
    TIPO_20 = 2'b01,
    TIPO_24 = 2'b10,
    TIPO_28 = 2'b11
  } tipo_e;

endpackage

// File: rtl/sign_extend_core.sv
// Combinational width-selectable sign extender.
// Ports:
//   tipo      in  2       field-width select (tipo_e)
//   entrada   in  IN_W    raw right-justified field; bits above the width are ignored
//   sin_signo in  1       zero-extend instead of sign-extend (only with SIGN_EXTEND_ZEXT_EN)
//   ext       out DATA_W  extended result
// Macro SIGN_EXTEND_ZEXT_EN adds the sin_signo input.
module sign_extend_core
  import sign_extend_pkg::*;
(
  input  logic [1:0]        tipo,
  input  logic [IN_W-1:0]   entrada,
`ifdef SIGN_EXTEND_ZEXT_EN
  input  logic              sin_signo,
`endif
  output logic [DATA_W-1:0] ext
);

  logic zext;

`ifdef SIGN_EXTEND_ZEXT_EN
  assign zext = sin_signo;
`else
  assign zext = 1'b0;
`endif

  // Each width slices only its own field so unused upper bits (even X/Z)
  // never reach the result.
  always_comb begin
    ext = '0;
    unique case (tipo_e'(tipo))
      TIPO_17: ext = {{(DATA_W - W17){entrada[W17-1] & ~zext}}, entrada[W17-1:0]};
      TIPO_20: ext = {{(DATA_W - W20){entrada[W20-1] & ~zext}}, entrada[W20-1:0]};
      TIPO_24: ext = {{(DATA_W - W24){entrada[W24-1] & ~zext}}, entrada[W24-1:0]};
      TIPO_28: ext = {{(DATA_W - W28){entrada[W28-1] & ~zext}}, entrada[W28-1:0]};
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/sign_extend.sv
// Registered sign-extension unit: extends a 17/20/24/28-bit immediate to 32 bits,
// result available one clock after an enabled edge.
// Ports:
//   clk       in  1   rising-edge clock
//   rst_n     in  1   asynchronous active-low reset
//   en        in  1   capture enable
//   sin_signo in  1   zero-extend select (only with SIGN_EXTEND_ZEXT_EN)
//   tipo      in  2   field-width select: 00=17b 01=20b 10=24b 11=28b
//   entrada   in  28  raw right-justified field
//   salida    out 32  registered extended result, held while en=0
//   valido    out 1   high for one cycle after each capture
// Macro SIGN_EXTEND_ZEXT_EN adds the sin_signo input.
module sign_extend
  import sign_extend_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
`ifdef SIGN_EXTEND_ZEXT_EN
  input  logic              sin_signo,
`endif
  input  logic [1:0]        tipo,
  input  logic [IN_W-1:0]   entrada,
  output logic [DATA_W-1:0] salida,
  output logic              valido
);

  logic [DATA_W-1:0] ext;
  logic [DATA_W-1:0] salida_d, salida_q;
  logic              valido_d, valido_q;

  sign_extend_core u_core (
    .tipo      (tipo),
    .entrada   (entrada),
`ifdef SIGN_EXTEND_ZEXT_EN
    .sin_signo (sin_signo),
`endif
    .ext       (ext)
  );

  always_comb begin
    salida_d = salida_q;
    valido_d = en;
    if (en) begin
      salida_d = ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      salida_q <= '0;
      valido_q <= 1'b0;
    end else begin
      salida_q <= salida_d;
      valido_q <= valido_d;
    end
  end

  assign salida = salida_q;
  assign valido = valido_q;

endmodule

// File: tb/tb_sign_extend.sv
module tb_sign_extend;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        sin_signo;
  logic [1:0]  tipo;
  logic [27:0] entrada;
  logic [31:0] salida;
  logic        valido;

  int checks;
  int errors;

  sign_extend dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
`ifdef SIGN_EXTEND_ZEXT_EN
    .sin_signo (sin_signo),
`endif
    .tipo      (tipo),
    .entrada   (entrada),
    .salida    (salida),
    .valido    (valido)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  tipo;
    logic [27:0] field;
    logic [31:0] expected;
  } vec_t;

  vec_t vecs [8];

  function automatic int width_of(input logic [1:0] t);
    case (t)
      2'b00:   return 17;
      2'b01:   return 20;
      2'b10:   return 24;
      default: return 28;
    endcase
  endfunction

  // Reference: interpret the low W bits as a two's-complement number (or unsigned
  // when zero-extending) and return it modulo 2^32.
  function automatic logic [31:0] model(input logic [1:0] t, input logic [27:0] e,
                                        input logic z);
    int    w;
    longint f;
    w = width_of(t);
    f = longint'(e) % (longint'(1) << w);
    if (!z && f >= (longint'(1) << (w - 1))) f = f - (longint'(1) << w);
    return f[31:0];
  endfunction

  // Fill bits above the field with random garbage.
  function automatic logic [27:0] dirty(input logic [1:0] t, input logic [27:0] field);
    logic [27:0] mask;
    logic [27:0] r;
    mask = 28'((longint'(1) << width_of(t)) - 1);
    r = 28'($urandom);
    return (r & ~mask) | (field & mask);
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_sal;
  logic        exp_val;

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    en        = 1'b0;
    sin_signo = 1'b0;
    tipo      = 2'b00;
    entrada   = '0;

    vecs[0] = '{2'b00, 28'h0017F54, 32'hFFFF7F54};
    vecs[1] = '{2'b00, 28'h00080AB, 32'h000080AB};
    vecs[2] = '{2'b01, 28'h00BFF54, 32'hFFFBFF54};
    vecs[3] = '{2'b01, 28'h00400AB, 32'h000400AB};
    vecs[4] = '{2'b10, 28'h0BFFAB9, 32'hFFBFFAB9};
    vecs[5] = '{2'b10, 28'h0401559, 32'h00401559};
    vecs[6] = '{2'b11, 28'hBBBFF54, 32'hFBBBFF54};
    vecs[7] = '{2'b11, 28'h44000AB, 32'h044000AB};

    #3;
    check32("reset_salida", salida, 32'h0);
    check1("reset_valido", valido, 1'b0);
    step();
    check1("reset_hold_valido", valido, 1'b0);
    rst_n = 1'b1;

    // Spec vectors, back-to-back captures
    for (int i = 0; i < 8; i++) begin
      tipo    = vecs[i].tipo;
      entrada = dirty(vecs[i].tipo, vecs[i].field);
      en      = 1'b1;
      step();
      check32($sformatf("vec%0d_salida", i), salida, vecs[i].expected);
      check1($sformatf("vec%0d_valido", i), valido, 1'b1);
    end

    // Hold: capture then disable and change inputs
    tipo    = 2'b11;
    entrada = 28'hBBBFF54;
    en      = 1'b1;
    step();
    check32("hold_capture", salida, 32'hFBBBFF54);
    en      = 1'b0;
    tipo    = 2'b00;
    entrada = 28'h0000001;
    step();
    check32("hold_salida", salida, 32'hFBBBFF54);
    check1("hold_valido", valido, 1'b0);
    tipo = 2'b01;
    step();
    check32("hold_salida2", salida, 32'hFBBBFF54);

    // Asynchronous reset between edges while a capture is in flight
    en      = 1'b1;
    tipo    = 2'b10;
    entrada = 28'h0BFFAB9;
    step();
    check32("pre_reset_capture", salida, 32'hFFBFFAB9);
    #2;
    rst_n = 1'b0;
    #1;
    check32("async_reset_salida", salida, 32'h0);
    check1("async_reset_valido", valido, 1'b0);
    step();
    check32("reset_held_salida", salida, 32'h0);
    check1("reset_held_valido", valido, 1'b0);
    en = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    check1("no_stale_valido", valido, 1'b0);
    check32("no_stale_salida", salida, 32'h0);
    en      = 1'b1;
    tipo    = 2'b00;
    entrada = 28'h0017F54;
    step();
    check32("first_after_release", salida, 32'hFFFF7F54);
    check1("first_after_release_v", valido, 1'b1);

`ifdef SIGN_EXTEND_ZEXT_EN
    sin_signo = 1'b1;
    tipo      = 2'b00;
    entrada   = dirty(2'b00, 28'h0017F54);
    step();
    check32("zext_17", salida, 32'h00017F54);
    sin_signo = 1'b0;
`endif

    // Randomized traffic against the reference model
    exp_sal = salida;
    for (int i = 0; i < 400; i++) begin
      en      = ($urandom_range(0, 3) != 0);
      tipo    = 2'($urandom_range(0, 3));
      entrada = 28'($urandom);
`ifdef SIGN_EXTEND_ZEXT_EN
      sin_signo = 1'($urandom_range(0, 1));
`endif
      if (en) exp_sal = model(tipo, entrada, sin_signo);
      exp_val = en;
      step();
      check32("rand_salida", salida, exp_sal);
      check1("rand_valido", valido, exp_val);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
